// File: rtl/kf8255_port_a_handshake.sv
// KF8255 group A port A data path: input/output latches plus the Mode 1/Mode 2
// STB#/ACK# handshakes that produce IBF, OBF#, INTR and the INTE enables.
module kf8255_port_a_handshake #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode_select_reg,
  input  logic       port_1_io_reg,
  input  logic       update_group_mode,
  input  logic [7:0] internal_data_bus,
  input  logic       write_port_a,
  input  logic       read_port_a,
  input  logic       bsr_write,
  input  logic [2:0] bsr_bit,
  input  logic       bsr_value,
  input  logic [7:0] port_a_in,
  input  logic       strobe_n,
  input  logic       ack_n,
  output logic [7:0] port_a_out,
  output logic       port_a_oe,
  output logic [7:0] read_data,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic       inte_in,
  output logic       inte_out
);

  logic [SYNC_STAGES-1:0] r_stb_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_stb_prev;
  logic                   r_ack_prev;

  logic [7:0] r_port_a_out;
  logic [7:0] r_in_latch;
  logic       r_ibf;
  logic       r_obf_n;
  logic       r_intr_in;
  logic       r_intr_out;
  logic       r_inte_in;
  logic       r_inte_out;

  logic [7:0] w_port_a_out_next;
  logic [7:0] w_in_latch_next;
  logic       w_ibf_next;
  logic       w_obf_n_next;
  logic       w_intr_in_next;
  logic       w_intr_out_next;
  logic       w_inte_in_next;
  logic       w_inte_out_next;

  logic w_mode0;
  logic w_mode1;
  logic w_mode2;
  logic w_in_active;
  logic w_out_active;
  logic w_stb_s;
  logic w_ack_s;
  logic w_stb_fall;
  logic w_stb_rise;
  logic w_ack_fall;
  logic w_ack_rise;
  logic w_intr_in_term;
  logic w_intr_out_term;

  assign w_mode0      = (mode_select_reg == 2'b00);
  assign w_mode1      = (mode_select_reg == 2'b01);
  assign w_mode2      = mode_select_reg[1];
  assign w_in_active  = (w_mode1 & port_1_io_reg) | w_mode2;
  assign w_out_active = (w_mode1 & ~port_1_io_reg) | w_mode2;

  // Synchronizers idle high so a released pin never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stb_sync <= '1;
      r_ack_sync <= '1;
      r_stb_prev <= 1'b1;
      r_ack_prev <= 1'b1;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], strobe_n};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_n};
      r_stb_prev <= w_stb_s;
      r_ack_prev <= w_ack_s;
    end
  end

  assign w_stb_s    = r_stb_sync[SYNC_STAGES-1];
  assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
  assign w_stb_fall = r_stb_prev & ~w_stb_s;
  assign w_stb_rise = ~r_stb_prev & w_stb_s;
  assign w_ack_fall = r_ack_prev & ~w_ack_s;
  assign w_ack_rise = ~r_ack_prev & w_ack_s;

  always_comb begin
    w_port_a_out_next = r_port_a_out;
    w_in_latch_next   = r_in_latch;
    w_ibf_next        = r_ibf;
    w_obf_n_next      = r_obf_n;
    w_intr_in_next    = r_intr_in;
    w_intr_out_next   = r_intr_out;
    w_inte_in_next    = r_inte_in;
    w_inte_out_next   = r_inte_out;

    if (write_port_a) begin
      w_port_a_out_next = internal_data_bus;
    end

    if (bsr_write) begin
      case (bsr_bit)
        3'd4:    w_inte_in_next  = bsr_value;
        3'd6:    w_inte_out_next = bsr_value;
        default: ;
      endcase
    end

    // A strobe fall outranks a simultaneous read so fresh data is never lost.
    if (w_in_active) begin
      if (w_stb_fall) begin
        w_in_latch_next = port_a_in;
        w_ibf_next      = 1'b1;
      end else if (read_port_a) begin
        w_ibf_next = 1'b0;
      end
      if (read_port_a) begin
        w_intr_in_next = 1'b0;
      end else if (w_stb_rise && r_ibf && r_inte_in) begin
        w_intr_in_next = 1'b1;
      end
    end else begin
      w_ibf_next     = 1'b0;
      w_intr_in_next = 1'b0;
    end

    // A CPU write outranks a simultaneous ACK# fall, keeping OBF# asserted.
    if (w_out_active) begin
      if (write_port_a) begin
        w_obf_n_next    = 1'b0;
        w_intr_out_next = 1'b0;
      end else begin
        if (w_ack_fall) begin
          w_obf_n_next = 1'b1;
        end
        if (w_ack_rise && r_obf_n && r_inte_out) begin
          w_intr_out_next = 1'b1;
        end
      end
    end else begin
      w_obf_n_next    = 1'b1;
      w_intr_out_next = 1'b0;
    end

    if (update_group_mode) begin
      w_port_a_out_next = 8'h00;
      w_in_latch_next   = 8'h00;
      w_ibf_next        = 1'b0;
      w_obf_n_next      = 1'b1;
      w_intr_in_next    = 1'b0;
      w_intr_out_next   = 1'b0;
      w_inte_in_next    = 1'b0;
      w_inte_out_next   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_port_a_out <= 8'h00;
      r_in_latch   <= 8'h00;
      r_ibf        <= 1'b0;
      r_obf_n      <= 1'b1;
      r_intr_in    <= 1'b0;
      r_intr_out   <= 1'b0;
      r_inte_in    <= 1'b0;
      r_inte_out   <= 1'b0;
    end else begin
      r_port_a_out <= w_port_a_out_next;
      r_in_latch   <= w_in_latch_next;
      r_ibf        <= w_ibf_next;
      r_obf_n      <= w_obf_n_next;
      r_intr_in    <= w_intr_in_next;
      r_intr_out   <= w_intr_out_next;
      r_inte_in    <= w_inte_in_next;
      r_inte_out   <= w_inte_out_next;
    end
  end

  // INTE gates the request combinationally so disabling it takes effect at once.
  assign w_intr_in_term  = r_intr_in & r_inte_in;
  assign w_intr_out_term = r_intr_out & r_inte_out;

  always_comb begin
    intr = 1'b0;
    if (w_mode2) begin
      intr = w_intr_in_term | w_intr_out_term;
    end else if (w_mode1) begin
      intr = port_1_io_reg ? w_intr_in_term : w_intr_out_term;
    end
  end

  always_comb begin
    read_data = r_in_latch;
    if (w_mode0) begin
      read_data = port_1_io_reg ? port_a_in : r_port_a_out;
    end else if (w_mode1 && !port_1_io_reg) begin
      read_data = r_port_a_out;
    end
  end

  assign port_a_oe  = w_mode2 ? ~w_ack_s : ~port_1_io_reg;
  assign port_a_out = r_port_a_out;
  assign ibf        = r_ibf;
  assign obf_n      = r_obf_n;
  assign inte_in    = r_inte_in;
  assign inte_out   = r_inte_out;

endmodule
